// File: rtl/pkt_pkg.sv
// -----------------------------------------------------------------------------
// pkt_pkg
// Shared definitions for the experiment packet stream: parser state encodings,
// framing constants, metadata field offsets and the port/MAC address table.
// The table is the single source for both directions of the port<->MAC map.
// -----------------------------------------------------------------------------
package pkt_pkg;

   typedef enum logic [3:0] {
      S_LEN_DMAC = 4'd0,
      S_DMAC_LO  = 4'd1,
      S_TIME_LO  = 4'd2,
      S_TIME_HI  = 4'd3,
      S_SMAC_HI  = 4'd4,
      S_SMAC_LO  = 4'd5,
      S_PAYLOAD  = 4'd6
   } state_e;

   localparam int unsigned HDR_WORDS   = 6;
   localparam int unsigned BLOCK_BYTES = 32;
   localparam int unsigned MAX_BLOCKS  = 63;
   localparam logic [31:0] PAYLOAD_WORD = 32'hFFFF_FFFF;

   // Largest legal length field in bytes (63 blocks of 32 bytes).
   localparam logic [15:0] MAX_LEN = 16'(MAX_BLOCKS * BLOCK_BYTES);

   // Words remaining counter: up to 504 words per packet.
   localparam int unsigned WL_W = 9;

   // Metadata word layout: {src_port, dst_port, len_blocks, timestamp}.
   localparam int unsigned SRC_LSB = 30;
   localparam int unsigned DST_LSB = 28;
   localparam int unsigned LEN_LSB = 22;
   localparam int unsigned TS_LSB  = 0;
   localparam int unsigned PORT_W  = 2;
   localparam int unsigned LEN_W   = 6;
   localparam int unsigned TS_W    = 22;

   localparam logic [47:0] PORT_MAC [0:3] = '{
      48'h02AA_0000_0000,
      48'h02AA_0000_0001,
      48'h02AA_0000_0002,
      48'h02AA_0000_0003
   };

   function automatic logic [47:0] port_to_mac(input logic [1:0] port);
      return PORT_MAC[port];
   endfunction

endpackage

// File: rtl/mac_to_port.sv
// -----------------------------------------------------------------------------
// mac_to_port
// Combinational reverse lookup of the port/MAC table.
//   mac  in  48  MAC address to look up
//   port out  2  matching port number, 0 when no entry matches
//   hit  out  1  high when the MAC matches a table entry
// -----------------------------------------------------------------------------
module mac_to_port
   import pkt_pkg::*;
(
   input  logic [47:0] mac,
   output logic [1:0]  port,
   output logic        hit
);

   always_comb begin
      port = '0;
      hit  = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (mac == PORT_MAC[i]) begin
            port = 2'(i);
            hit  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/packet_parse.sv
// -----------------------------------------------------------------------------
// packet_parse
// Parses the experiment generator word stream (length+DMAC, DMAC low,
// timestamp low/high, SMAC high/low, all-ones payload), checks framing and
// content, and recovers the packet metadata word for egress statistics.
//   clk           in   system clock
//   reset         in   asynchronous reset, active low
//   packet_in_en  in   word valid, consumed when high (no backpressure)
//   packet_in     in   32-bit stream word
//   meta_out_en   out  one-cycle pulse per completed packet
//   meta_out      out  {src_port, dst_port, len_blocks, timestamp}, held
//   meta_err      out  packet had at least one content error
//   pkt_cnt       out  completed packets, saturating
//   err_cnt       out  errored packets plus rejected length words, saturating
// -----------------------------------------------------------------------------
module packet_parse
   import pkt_pkg::*;
#(
   parameter int unsigned META_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  packet_in_en,
   input  logic [31:0]           packet_in,
   output logic                  meta_out_en,
   output logic [META_WIDTH-1:0] meta_out,
   output logic                  meta_err,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt
);

   state_e                state_q, state_d;
   logic [WL_W-1:0]       words_left_q, words_left_d;
   logic [LEN_W-1:0]      len_blocks_q, len_blocks_d;
   logic [47:0]           dmac_q, dmac_d;
   logic [47:0]           smac_q, smac_d;
   logic [TS_W-1:0]       ts_q, ts_d;
   logic                  err_flag_q, err_flag_d;
   logic                  meta_out_en_q, meta_out_en_d;
   logic [META_WIDTH-1:0] meta_out_q, meta_out_d;
   logic                  meta_err_q, meta_err_d;
   logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
   logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

   logic [15:0]           len_word;
   logic                  len_ok;
   logic                  word_err;
   logic                  len_rej;
   logic                  pkt_done;
   logic                  err_inc;
   logic [31:0]           meta_word;
   logic [1:0]            dst_port, src_port;
   logic                  dst_hit, src_hit;

   mac_to_port u_dmac_lookup (
      .mac  (dmac_q),
      .port (dst_port),
      .hit  (dst_hit)
   );

   mac_to_port u_smac_lookup (
      .mac  (smac_q),
      .port (src_port),
      .hit  (src_hit)
   );

   assign len_word = packet_in[31:16];
   // Whole 32-byte blocks only, 1..63 of them.
   assign len_ok   = (len_word != '0) && (len_word[4:0] == '0) && (len_word <= MAX_LEN);

   always_comb begin
      meta_word = '0;
      meta_word[SRC_LSB +: PORT_W] = src_port;
      meta_word[DST_LSB +: PORT_W] = dst_port;
      meta_word[LEN_LSB +: LEN_W]  = len_blocks_q;
      meta_word[TS_LSB  +: TS_W]   = ts_q;
   end

   always_comb begin
      state_d       = state_q;
      words_left_d  = words_left_q;
      len_blocks_d  = len_blocks_q;
      dmac_d        = dmac_q;
      smac_d        = smac_q;
      ts_d          = ts_q;
      err_flag_d    = err_flag_q;
      meta_out_en_d = 1'b0;
      meta_out_d    = meta_out_q;
      meta_err_d    = meta_err_q;
      pkt_cnt_d     = pkt_cnt_q;
      err_cnt_d     = err_cnt_q;
      word_err      = 1'b0;
      len_rej       = 1'b0;
      pkt_done      = 1'b0;

      if (packet_in_en) begin
         if (state_q == S_LEN_DMAC) begin
            if (len_ok) begin
               err_flag_d     = 1'b0;
               words_left_d   = len_word[10:2] - WL_W'(1);
               len_blocks_d   = len_word[10:5];
               dmac_d[47:32]  = packet_in[15:0];
               state_d        = S_DMAC_LO;
            end else begin
               // Hunt mode: stay here until a plausible length word shows up.
               len_rej = 1'b1;
            end
         end else begin
            words_left_d = words_left_q - WL_W'(1);
            case (state_q)
               S_DMAC_LO: begin
                  dmac_d[31:0] = packet_in;
                  state_d      = S_TIME_LO;
               end
               S_TIME_LO: begin
                  ts_d     = packet_in[21:0];
                  word_err = (packet_in[31:22] != '0);
                  state_d  = S_TIME_HI;
               end
               S_TIME_HI: begin
                  word_err = (packet_in != '0);
                  state_d  = S_SMAC_HI;
               end
               S_SMAC_HI: begin
                  smac_d[47:32] = packet_in[15:0];
                  word_err      = (packet_in[31:16] != '0);
                  state_d       = S_SMAC_LO;
               end
               S_SMAC_LO: begin
                  smac_d[31:0] = packet_in;
                  state_d      = S_PAYLOAD;
               end
               S_PAYLOAD: begin
                  word_err = (packet_in != PAYLOAD_WORD);
               end
               default: begin
                  state_d = S_LEN_DMAC;
               end
            endcase
            err_flag_d = err_flag_q | word_err;
            if (words_left_q == WL_W'(1)) begin
               pkt_done = 1'b1;
               state_d  = S_LEN_DMAC;
            end
         end
      end

      // Both MACs are fully latched before the last word, so the table misses
      // are folded in here together with an error on the last word itself.
      if (pkt_done) begin
         meta_out_en_d = 1'b1;
         meta_out_d    = META_WIDTH'(meta_word);
         meta_err_d    = err_flag_q | word_err | ~dst_hit | ~src_hit;
         if (pkt_cnt_q != '1) begin
            pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
         end
      end

      err_inc = len_rej | (pkt_done & meta_err_d);
      if (err_inc && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_LEN_DMAC;
         words_left_q  <= '0;
         len_blocks_q  <= '0;
         dmac_q        <= '0;
         smac_q        <= '0;
         ts_q          <= '0;
         err_flag_q    <= 1'b0;
         meta_out_en_q <= 1'b0;
         meta_out_q    <= '0;
         meta_err_q    <= 1'b0;
         pkt_cnt_q     <= '0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         words_left_q  <= words_left_d;
         len_blocks_q  <= len_blocks_d;
         dmac_q        <= dmac_d;
         smac_q        <= smac_d;
         ts_q          <= ts_d;
         err_flag_q    <= err_flag_d;
         meta_out_en_q <= meta_out_en_d;
         meta_out_q    <= meta_out_d;
         meta_err_q    <= meta_err_d;
         pkt_cnt_q     <= pkt_cnt_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign meta_out_en = meta_out_en_q;
   assign meta_out    = meta_out_q;
   assign meta_err    = meta_err_q;
   assign pkt_cnt     = pkt_cnt_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_packet_parse.sv
// -----------------------------------------------------------------------------
// tb_packet_parse
// Directed bench for packet_parse. Counters run with a 4-bit width so that
// saturation is reachable in a short run; counts accumulate across tests.
// -----------------------------------------------------------------------------
module tb_packet_parse;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          packet_in_en = 1'b0;
   logic [31:0]   packet_in = '0;
   logic          meta_out_en;
   logic [31:0]   meta_out;
   logic          meta_err;
   logic [CW-1:0] pkt_cnt;
   logic [CW-1:0] err_cnt;

   int n_checks = 0;
   int n_errors = 0;

   logic [32:0] pulses[$];

   packet_parse #(
      .META_WIDTH (32),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .packet_in_en (packet_in_en),
      .packet_in    (packet_in),
      .meta_out_en  (meta_out_en),
      .meta_out     (meta_out),
      .meta_err     (meta_err),
      .pkt_cnt      (pkt_cnt),
      .err_cnt      (err_cnt)
   );

   always #5 clk = ~clk;

   // Record every completion pulse as {meta_err, meta_out}.
   always @(posedge clk) begin
      #1;
      if (meta_out_en === 1'b1) pulses.push_back({meta_err, meta_out});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] mac_of(input logic [1:0] p);
      logic [47:0] m;
      m = 48'h02AA_0000_0000;
      m[1:0] = p;
      return m;
   endfunction

   function automatic logic [32:0] pulse_at(input int idx);
      if (idx < pulses.size()) return pulses[idx];
      return 33'h0_DEAD_BEEF;
   endfunction

   function automatic logic [31:0] pkt_word(input int i, input logic [15:0] len,
                                            input logic [47:0] dmac, input logic [47:0] smac,
                                            input logic [21:0] ts);
      case (i)
         0:       return {len, dmac[47:32]};
         1:       return dmac[31:0];
         2:       return {10'b0, ts};
         3:       return 32'h0;
         4:       return {16'h0, smac[47:32]};
         5:       return smac[31:0];
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Drives one packet; packet_in_en stays high after the last word so the
   // next call can follow back-to-back. stop_after = 0 sends the whole packet.
   task automatic send_pkt(input logic [47:0] smac, input logic [47:0] dmac, input int blocks,
                           input logic [21:0] ts, input int bad_idx, input logic [31:0] bad_val,
                           input bit gaps, input int stop_after);
      int n;
      logic [31:0] w;
      n = blocks * 8;
      if (stop_after > 0) n = stop_after;
      for (int i = 0; i < n; i++) begin
         w = pkt_word(i, 16'(blocks * 32), dmac, smac, ts);
         if (i == bad_idx) w = bad_val;
         @(negedge clk);
         packet_in_en = 1'b1;
         packet_in    = w;
         if (gaps && (i != n - 1) && ($urandom_range(0, 3) == 0)) begin
            repeat ($urandom_range(1, 3)) begin
               @(negedge clk);
               packet_in_en = 1'b0;
               packet_in    = $urandom;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         packet_in_en = 1'b0;
         packet_in    = '0;
      end
   endtask

   int base;

   initial begin
      // Reset state
      #1;
      check("rst_en",   32'(meta_out_en), 32'h0);
      check("rst_meta", meta_out,         32'h0);
      check("rst_err",  32'(meta_err),    32'h0);
      check("rst_pkt",  32'(pkt_cnt),     32'h0);
      check("rst_ecnt", 32'(err_cnt),     32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      idle(2);

      // 1-block packet, src 2, dst 1, contiguous; check 1-cycle latency
      base = pulses.size();
      send_pkt(mac_of(2'd2), mac_of(2'd1), 1, 22'h12345, -1, 32'h0, 1'b0, 0);
      @(posedge clk);
      #1;
      check("t1_lat_en",   32'(meta_out_en), 32'h1);
      check("t1_lat_meta", meta_out,         32'h9041_2345);
      idle(3);
      check("t1_npulse", 32'(pulses.size() - base), 32'd1);
      check("t1_meta",   pulse_at(base)[31:0],      32'h9041_2345);
      check("t1_err",    32'(pulse_at(base)[32]),   32'h0);
      check("t1_hold",   meta_out,                  32'h9041_2345);
      check("t1_pkt",    32'(pkt_cnt),              32'd1);
      check("t1_ecnt",   32'(err_cnt),              32'd0);

      // 63-block packet with gaps, then an immediate 1-block packet
      base = pulses.size();
      send_pkt(mac_of(2'd0), mac_of(2'd3), 63, 22'h3FFFFF, -1, 32'h0, 1'b1, 0);
      send_pkt(mac_of(2'd3), mac_of(2'd0), 1, 22'h0, -1, 32'h0, 1'b0, 0);
      idle(3);
      check("t2_npulse", 32'(pulses.size() - base),   32'd2);
      check("t2_meta0",  pulse_at(base)[31:0],        32'h3FFF_FFFF);
      check("t2_err0",   32'(pulse_at(base)[32]),     32'h0);
      check("t2_meta1",  pulse_at(base + 1)[31:0],    32'hC040_0000);
      check("t2_err1",   32'(pulse_at(base + 1)[32]), 32'h0);
      check("t2_pkt",    32'(pkt_cnt),                32'd3);

      // 2-block packet with a bad payload word 9, then a clean packet
      base = pulses.size();
      send_pkt(mac_of(2'd1), mac_of(2'd2), 2, 22'h00ABC, 9, 32'hFFFF_FFFE, 1'b0, 0);
      idle(2);
      check("t3_npulse", 32'(pulses.size() - base), 32'd1);
      check("t3_meta",   pulse_at(base)[31:0],      32'h6080_0ABC);
      check("t3_err",    32'(pulse_at(base)[32]),   32'h1);
      check("t3_ecnt",   32'(err_cnt),              32'd1);
      send_pkt(mac_of(2'd0), mac_of(2'd0), 1, 22'h1, -1, 32'h0, 1'b0, 0);
      idle(2);
      check("t3b_meta",  pulse_at(base + 1)[31:0],    32'h0040_0001);
      check("t3b_err",   32'(pulse_at(base + 1)[32]), 32'h0);
      check("t3b_pkt",   32'(pkt_cnt),                32'd5);
      check("t3b_ecnt",  32'(err_cnt),                32'd1);

      // Rejected length words, then recovery
      base = pulses.size();
      @(negedge clk); packet_in_en = 1'b1; packet_in = 32'h0000_02AA;
      @(negedge clk); packet_in_en = 1'b1; packet_in = 32'h0021_02AA;
      @(negedge clk); packet_in_en = 1'b1; packet_in = 32'h0800_02AA;
      idle(2);
      check("t4_npulse", 32'(pulses.size() - base), 32'd0);
      check("t4_ecnt",   32'(err_cnt),              32'd4);
      send_pkt(mac_of(2'd1), mac_of(2'd1), 4, 22'h155, -1, 32'h0, 1'b0, 0);
      idle(2);
      check("t4b_npulse", 32'(pulses.size() - base), 32'd1);
      check("t4b_meta",   pulse_at(base)[31:0],      32'h5100_0155);
      check("t4b_err",    32'(pulse_at(base)[32]),   32'h0);
      check("t4b_pkt",    32'(pkt_cnt),              32'd6);

      // Unknown SMAC
      base = pulses.size();
      send_pkt(48'h02AA_0000_0007, mac_of(2'd2), 1, 22'h10, -1, 32'h0, 1'b0, 0);
      idle(2);
      check("t5_meta", pulse_at(base)[31:0],    32'h2040_0010);
      check("t5_err",  32'(pulse_at(base)[32]), 32'h1);
      check("t5_ecnt", 32'(err_cnt),            32'd5);

      // Saturation of both counters
      base = pulses.size();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); packet_in_en = 1'b1; packet_in = 32'h0001_0000;
      end
      idle(1);
      check("sat_ecnt", 32'(err_cnt), 32'd15);
      for (int i = 0; i < 9; i++) begin
         send_pkt(mac_of(2'd0), mac_of(2'd0), 1, 22'(i), -1, 32'h0, 1'b0, 0);
      end
      idle(2);
      check("sat_npulse", 32'(pulses.size() - base), 32'd9);
      check("sat_pkt",    32'(pkt_cnt),              32'd15);
      check("sat_ecnt2",  32'(err_cnt),              32'd15);

      // Reset in the middle of a 4-block packet
      base = pulses.size();
      send_pkt(mac_of(2'd2), mac_of(2'd2), 4, 22'h77, -1, 32'h0, 1'b0, 5);
      @(negedge clk);
      packet_in_en = 1'b0;
      reset = 1'b0;
      #1;
      check("t6_rst_en",   32'(meta_out_en), 32'h0);
      check("t6_rst_meta", meta_out,         32'h0);
      check("t6_rst_err",  32'(meta_err),    32'h0);
      check("t6_rst_pkt",  32'(pkt_cnt),     32'h0);
      check("t6_rst_ecnt", 32'(err_cnt),     32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      idle(1);
      send_pkt(mac_of(2'd3), mac_of(2'd3), 1, 22'h2A, -1, 32'h0, 1'b0, 0);
      idle(2);
      check("t6_npulse", 32'(pulses.size() - base), 32'd1);
      check("t6_meta",   pulse_at(base)[31:0],      32'hF040_002A);
      check("t6_err",    32'(pulse_at(base)[32]),   32'h0);
      check("t6_pkt",    32'(pkt_cnt),              32'd1);
      check("t6_ecnt",   32'(err_cnt),              32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/packet_parse.md
# packet_parse

Receive-side counterpart of the experiment packet generator. Consumes the 32-bit word stream the generator produces (length+DMAC, timestamp, SMAC, all-ones payload), validates framing and content, and recovers the original 32-bit packet metadata word for the egress statistics logic. Sits at each egress port output in experiment mode.

## Interface

Parameters:
- META_WIDTH, 32, width of the recovered metadata word
- CNT_WIDTH, 16, width of the packet and error counters

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- packet_in_en  in  1  word valid; each word is consumed on the cycle it is high, with no backpressure
- packet_in  in  32  stream word
- meta_out_en  out  1  one-cycle pulse: packet complete
- meta_out  out  META_WIDTH  {src_port[31:30], dst_port[29:28], len_blocks[27:22], timestamp[21:0]}
- meta_err  out  1  qualifies meta_out_en: packet had one or more content errors
- pkt_cnt  out  CNT_WIDTH  completed packets, saturating
- err_cnt  out  CNT_WIDTH  packets with errors plus rejected length words, saturating

## Operation

- States: S_LEN_DMAC, S_DMAC_LO, S_TIME_LO, S_TIME_HI, S_SMAC_HI, S_SMAC_LO, S_PAYLOAD. The FSM advances only on cycles where packet_in_en is high.
- S_LEN_DMAC: len = packet_in[31:16]; latch DMAC[47:32] = packet_in[15:0].
  - Length is valid if len != 0, len[4:0] == 0, and len <= 2016 (63 blocks). In that case, set words_left = len/4 − 1, latch len_blocks = len[10:5], and move to S_DMAC_LO.
  - Invalid length: increment err_cnt, stay in S_LEN_DMAC (hunt mode), and emit no meta_out.
- S_DMAC_LO: DMAC[31:0] = packet_in.
- S_TIME_LO: timestamp = packet_in[21:0]. packet_in[31:22] != 0 sets err_flag.
- S_TIME_HI: packet_in != 0 sets err_flag.
- S_SMAC_HI: packet_in[31:16] != 0 sets err_flag; latch SMAC[47:32].
- S_SMAC_LO: latch SMAC[31:0].
- S_PAYLOAD: packet_in != 32'hFFFF_FFFF sets err_flag.
- Every accepted word after the first decrements words_left. When the word with words_left == 1 is accepted (the last word), return to S_LEN_DMAC.
- Every valid length has at least 8 words: 6 header words plus 2 or more payload words.
- Port mapping:
  - DMAC maps to dst_port and SMAC maps to src_port through mac_to_port.
  - A MAC that matches no table entry sets err_flag; the port field is then 0.
- err_flag clears at each new valid length word.
- On completion: pkt_cnt increments, and err_cnt increments if err_flag is set (an error in the last word counts).

## Timing

- Reset values: state = S_LEN_DMAC; meta_out_en = 0; meta_out = 0; meta_err = 0; pkt_cnt = 0; err_cnt = 0; words_left = 0.
- Latency: meta_out_en, meta_out and meta_err are registered and assert exactly 1 cycle after the last word's packet_in_en cycle. meta_out holds its value until the next completion.
- Gaps: packet_in_en low cycles anywhere in a packet are allowed and do not affect the result.
- Back-to-back packets: a new packet's first word may arrive on the same cycle as the previous packet's meta_out_en pulse.
- Counters: both saturate at all-ones and never wrap.
- Simultaneous events: a packet completing with an error and a rejected length word cannot occur on the same cycle, because they are different states. err_cnt is still written from a single increment expression.
- Reset mid-packet: the partial packet is discarded with no meta_out_en, and parsing restarts at S_LEN_DMAC.

## Structure

- Shared package pkt_pkg holds:
  - State encodings (4-bit).
  - HDR_WORDS = 6, BLOCK_BYTES = 32, MAX_BLOCKS = 63, PAYLOAD_WORD = 32'hFFFF_FFFF.
  - The metadata field offsets.
  - The PORT_MAC[0:3] table, which port_to_mac is also refactored to use.
- One sub-module, mac_to_port: combinational lookup, 48-bit MAC in, 2-bit port out, plus a hit flag. Two instances: DMAC and SMAC.

## Test plan

- 1-block packet, src 2, dst 1, timestamp 0x12345, 8 contiguous words → one meta_out_en pulse with meta_out = 0x90412345, meta_err = 0, pkt_cnt = 1.
- 63-block packet (504 words) with random packet_in_en gaps, then an immediate 1-block packet → two pulses with len_blocks 63 and then 1, pkt_cnt = 2.
- 2-block packet with payload word 9 = 0xFFFF_FFFE → meta_out_en pulse with meta_err = 1, err_cnt = 1, and the following packet parses cleanly.
- Length words 0x0000, 0x0021 and 0x0800 → no pulses, err_cnt = 3; a subsequent valid packet is recovered.
- SMAC not in the table → meta_err = 1 with the src_port field = 0.
- reset driven low after word 5 of a 4-block packet → all outputs 0 while reset is low; the next full packet parses correctly with pkt_cnt = 1.
